hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch redirect/flush, data-memory freeze.
// Latency: all outputs are combinational from current state and inputs (same-cycle response).
// Backpressure: dmem_busy freezes every stage and parks the FSM until the memory is ready.
// Optional build macro HAZARD_PERF_EN adds saturating stall/redirect performance counters.
module hazard_ctrl #(
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_target,
  input  logic        dmem_busy,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEMWAIT  = 2'd2
  } st_e;

  // Redirect-state cycles that follow the branch cycle itself.
  localparam logic [3:0] RCNT_INIT = 4'(REDIRECT_CYCLES - 1);
  localparam bit         USE_REDIRECT_ST = (REDIRECT_CYCLES > 1);

  st_e        st_q, st_d;
  st_e        ret_st_q, ret_st_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] rcnt_sv_q, rcnt_sv_d;

  // Effective state: MEMWAIT resumes as whatever it interrupted.
  st_e        eff_st;
  logic [3:0] eff_rcnt;

  logic       lu;
  logic       br_taken;

  logic        stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
  logic        flush_id_c, flush_ex_c, pc_redirect_c;
  logic [31:0] redirect_pc_c;

  // Load in EX writing a register that ID is about to read; x0 never hazards.
  always_comb begin
    lu = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) & id_valid &
         ((id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    br_taken = ex_valid & ex_branch_taken;
  end

  // Next-state and output decode, priority: dmem_busy > branch > load-use.
  always_comb begin
    st_d          = st_q;
    ret_st_d      = ret_st_q;
    rcnt_d        = rcnt_q;
    rcnt_sv_d     = rcnt_sv_q;
    stall_if_c    = 1'b0;
    stall_id_c    = 1'b0;
    stall_ex_c    = 1'b0;
    stall_mem_c   = 1'b0;
    flush_id_c    = 1'b0;
    flush_ex_c    = 1'b0;
    pc_redirect_c = 1'b0;
    redirect_pc_c = 32'd0;

    eff_st   = (st_q == ST_MEMWAIT) ? ret_st_q  : st_q;
    eff_rcnt = (st_q == ST_MEMWAIT) ? rcnt_sv_q : rcnt_q;

    if (dmem_busy) begin
      // Freeze everything; remember where we were so it can resume unchanged.
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      stall_ex_c  = 1'b1;
      stall_mem_c = 1'b1;
      if (st_q != ST_MEMWAIT) begin
        st_d      = ST_MEMWAIT;
        ret_st_d  = st_q;
        rcnt_sv_d = rcnt_q;
      end
    end else if (eff_st == ST_REDIRECT) begin
      // Keep squashing wrong-path fetches; branch and load-use are irrelevant here.
      flush_id_c = 1'b1;
      flush_ex_c = 1'b1;
      rcnt_d     = (eff_rcnt > 4'd1) ? (eff_rcnt - 4'd1) : 4'd0;
      st_d       = (eff_rcnt > 4'd1) ? ST_REDIRECT : ST_RUN;
      ret_st_d   = ST_RUN;
    end else begin
      st_d     = ST_RUN;
      rcnt_d   = 4'd0;
      ret_st_d = ST_RUN;
      if (br_taken) begin
        pc_redirect_c = 1'b1;
        redirect_pc_c = ex_target;
        flush_id_c    = 1'b1;
        flush_ex_c    = 1'b1;
        if (USE_REDIRECT_ST) begin
          st_d   = ST_REDIRECT;
          rcnt_d = RCNT_INIT;
        end
      end else if (lu) begin
        // Hold IF/ID one cycle and push a bubble into EX while the load completes.
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        flush_ex_c = 1'b1;
      end
    end
  end

  // While reset is asserted every control output is forced low.
  always_comb begin
    stall_if    = rst_ & stall_if_c;
    stall_id    = rst_ & stall_id_c;
    stall_ex    = rst_ & stall_ex_c;
    stall_mem   = rst_ & stall_mem_c;
    flush_id    = rst_ & flush_id_c;
    flush_ex    = rst_ & flush_ex_c;
    pc_redirect = rst_ & pc_redirect_c;
    redirect_pc = rst_ ? redirect_pc_c : 32'd0;
  end

  // FSM state, redirect counter and MEMWAIT save registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_q      <= ST_RUN;
      ret_st_q  <= ST_RUN;
      rcnt_q    <= 4'd0;
      rcnt_sv_q <= 4'd0;
    end else begin
      st_q      <= st_d;
      ret_st_q  <= ret_st_d;
      rcnt_q    <= rcnt_d;
      rcnt_sv_q <= rcnt_sv_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_redir_q;

  // Saturating event counters for stall and redirect cycles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      perf_stall_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      if (stall_if_c && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (pc_redirect_c && (perf_redir_q != 32'hFFFF_FFFF)) begin
        perf_redir_q <= perf_redir_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule
